vga_scan: RTL
=============

VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: clk cycles per pixel tick, legal range 1..16.
REQ-002 The block SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal timing in pixel ticks.
REQ-003 The block SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines.
REQ-004 The block SHALL have parameter PIPE_LAT, default 1: pixel-source latency in pixel ticks, legal range 0..3.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port color, input, 12 bits: RGB444 pixel from the pixel source, valid PIPE_LAT ticks after its coordinates.
REQ-008 The block SHALL have port vga_x, output, 10 bits: current active-column coordinate sent to the pixel source.
REQ-009 The block SHALL have port vga_y, output, 9 bits: current active-row coordinate sent to the pixel source.
REQ-010 The block SHALL have port pix_en, output, 1 bit: one-clk pixel-tick strobe.
REQ-011 The block SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-012 The block SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-013 The block SHALL have ports vga_r, vga_g and vga_b, output, 4 bits each: the DAC drive.

Function
REQ-014 The divider SHALL count 0..CLK_DIV-1, and pix_en SHALL be high for exactly the one clk in which the divider is CLK_DIV-1.
REQ-015 When CLK_DIV=1, pix_en SHALL be high on every clk.
REQ-016 h_cnt SHALL be 10 bits and advance only on pix_en, wrapping from H_TOTAL-1 to 0, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
REQ-017 v_cnt SHALL be 10 bits and advance only on the pix_en where h_cnt wraps, wrapping from V_TOTAL-1 to 0, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-018 When h_cnt and v_cnt wrap on the same pix_en, both SHALL become 0 on that edge.
REQ-019 active SHALL equal (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
REQ-020 vga_x SHALL be h_cnt while h_cnt < H_ACTIVE and 0 otherwise; vga_y SHALL be v_cnt[8:0] while v_cnt < V_ACTIVE and 0 otherwise; both are combinational from the counters.
REQ-021 The raw hsync SHALL be low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; the raw vsync SHALL be low when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
REQ-022 active, hsync and vsync SHALL pass through a PIPE_LAT-stage shift register that advances only on pix_en; with PIPE_LAT=0 there SHALL be no delay stage.
REQ-023 vga_r, vga_g and vga_b SHALL be registered on pix_en from color[11:8], color[7:4] and color[3:0] when delayed active=1, and 0 otherwise.
REQ-024 Registered RGB, hsync and vsync SHALL change only on clk edges where pix_en=1, and SHALL hold between ticks.
REQ-025 Delayed hsync and vsync SHALL be registered alongside RGB so that all DAC outputs switch on the same edge.

Reset
REQ-026 While rst=1, the divider, h_cnt, v_cnt and all delay stages SHALL clear to 0, with delay stages holding active=0, hsync=1 and vsync=1.
REQ-027 While rst=1, vga_r, vga_g and vga_b SHALL be 0, hsync and vsync SHALL be 1, pix_en SHALL be 0, and vga_x and vga_y SHALL be 0.
REQ-028 A reset asserted mid-line or mid-frame SHALL abandon the frame; after release, the first pix_en SHALL occur CLK_DIV clks later with h_cnt=0 and v_cnt=0.

Configuration
REQ-029 With VGA_SCAN_FRAME_PULSE_EN defined, the block SHALL provide an extra output frame_start (1 bit), high for one clk on the pix_en edge where v_cnt wraps to 0, and 0 during reset.
REQ-030 Without VGA_SCAN_FRAME_PULSE_EN, the frame_start port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset and cadence: rst high for 3 clks, then low with CLK_DIV=4 -> pix_en first high 4 clks after release, then every 4 clks; hsync=vsync=1 and RGB=0 during reset.
REQ-032 Line timing: run one line -> hsync low for exactly 96 ticks beginning when h_cnt=656 (plus PIPE_LAT ticks); line period 800 ticks = 3200 clks.
REQ-033 Frame timing: run a full frame -> vsync low for 2 lines beginning at v_cnt=490; frame period 420000 ticks; h_cnt and v_cnt both wrap 799/524 -> 0 on the same edge.
REQ-034 Blanking and latency: color tied to 12'hABC with PIPE_LAT=1 -> RGB=A,B,C one tick after each active coordinate and 0 throughout blanking; vga_x=0 and vga_y=0 when h_cnt>=640.
REQ-035 Mid-frame reset: pulse rst for 1 clk at v_cnt=300, h_cnt=400 -> counters restart at 0,0 and the sync pattern matches a fresh frame.
REQ-036 Macro and divider: with VGA_SCAN_FRAME_PULSE_EN defined, frame_start is one clk wide once per 525 lines; with CLK_DIV=1, pix_en stays constantly high.

Source files
------------

// File: rtl/vga_scan.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan
// Brief    : VGA raster timing generator with pixel-source latency alignment.
//            Optional frame_start pulse when VGA_SCAN_FRAME_PULSE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] color,
  output logic [9:0]  vga_x,
  output logic [8:0]  vga_y,
  output logic        pix_en,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
`ifdef VGA_SCAN_FRAME_PULSE_EN
  ,
  output logic        frame_start
`endif
);

  localparam int         c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] c_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] c_HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0] c_DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] r_div;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       w_tick;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       w_h_act;
  logic       w_v_act;
  logic       w_active;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic       w_active_d;
  logic       w_hs_d;
  logic       w_vs_d;
  logic [3:0] r_r;
  logic [3:0] r_g;
  logic [3:0] r_b;
  logic       r_hs;
  logic       r_vs;

  // Gating with rst keeps the strobe low in reset even when CLK_DIV=1.
  assign w_tick = (r_div == c_DIV_LAST) && !rst;
  assign pix_en = w_tick;

  always_ff @(posedge clk) begin
    if (rst || (r_div == c_DIV_LAST)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 4'd1;
    end
  end

  assign w_h_wrap = (r_h_cnt == c_H_LAST);
  assign w_v_wrap = (r_v_cnt == c_V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_tick) begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  assign w_h_act  = (r_h_cnt < c_H_ACT);
  assign w_v_act  = (r_v_cnt < c_V_ACT);
  assign w_active = w_h_act && w_v_act;
  assign w_hs_raw = !((r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END));
  assign w_vs_raw = !((r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END));
  assign vga_x    = w_h_act ? r_h_cnt : 10'd0;
  assign vga_y    = w_v_act ? r_v_cnt[8:0] : 9'd0;

  // Delay the timing flags so they line up with the pixel source's colour.
  generate
    if (PIPE_LAT == 0) begin : g_no_pipe
      assign w_active_d = w_active;
      assign w_hs_d     = w_hs_raw;
      assign w_vs_d     = w_vs_raw;
    end else begin : g_pipe
      logic [PIPE_LAT-1:0] r_act_sr;
      logic [PIPE_LAT-1:0] r_hs_sr;
      logic [PIPE_LAT-1:0] r_vs_sr;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_act_sr <= '0;
          r_hs_sr  <= '1;
          r_vs_sr  <= '1;
        end else if (w_tick) begin
          r_act_sr[0] <= w_active;
          r_hs_sr[0]  <= w_hs_raw;
          r_vs_sr[0]  <= w_vs_raw;
          for (int i = 1; i < PIPE_LAT; i++) begin
            r_act_sr[i] <= r_act_sr[i-1];
            r_hs_sr[i]  <= r_hs_sr[i-1];
            r_vs_sr[i]  <= r_vs_sr[i-1];
          end
        end
      end

      assign w_active_d = r_act_sr[PIPE_LAT-1];
      assign w_hs_d     = r_hs_sr[PIPE_LAT-1];
      assign w_vs_d     = r_vs_sr[PIPE_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
      r_hs <= 1'b1;
      r_vs <= 1'b1;
    end else if (w_tick) begin
      r_r  <= w_active_d ? color[11:8] : 4'd0;
      r_g  <= w_active_d ? color[7:4]  : 4'd0;
      r_b  <= w_active_d ? color[3:0]  : 4'd0;
      r_hs <= w_hs_d;
      r_vs <= w_vs_d;
    end
  end

  assign vga_r = r_r;
  assign vga_g = r_g;
  assign vga_b = r_b;
  assign hsync = r_hs;
  assign vsync = r_vs;

`ifdef VGA_SCAN_FRAME_PULSE_EN
  logic r_frame_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
    end
  end

  assign frame_start = r_frame_start;
`endif

endmodule
`default_nettype wire
